// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the EX-side of the five-stage pipeline.
//   - ALU operation codes driven onto the ALU's 4-bit operation input
//   - ALU-op encodings produced by the main decoder
//   - R-type funct constants
//   - ID/EX latch layout and small decode/hazard helpers
package pipe_pkg;

  localparam int XLEN = 32;
  localparam int RIDX = 5;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOP = 4'b1111   // ALU drives 0
  } alu_opc_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ID/EX latch contents. An all-zero value is both the reset state and a bubble.
  typedef struct packed {
    logic            valid;
    logic [RIDX-1:0] rs;
    logic [RIDX-1:0] rt;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    alu_opc_e        op;
    logic [RIDX-1:0] dest;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
  } idex_t;

  function automatic alu_opc_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_opc_e r;
    r = OP_NOP;
    case (alu_op)
      ALUOP_ADD:   r = OP_ADD;
      ALUOP_SUB:   r = OP_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  r = OP_ADD;
          FN_SUB:  r = OP_SUB;
          FN_AND:  r = OP_AND;
          FN_OR:   r = OP_OR;
          FN_SLT:  r = OP_SLT;
          default: r = OP_NOP;
        endcase
      end
      default:     r = OP_NOP;
    endcase
    return r;
  endfunction

  // True when a producer (we, dst) feeds a source the ID instruction actually reads.
  // rt only counts when it is a real operand (register B) or the store data.
  function automatic logic src_hit(input logic we, input logic [RIDX-1:0] dst,
                                   input logic [RIDX-1:0] rs, input logic [RIDX-1:0] rt,
                                   input logic uses_rt);
    return we && (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/id_ex_issue_forward.sv
// ex_forward_unit: resolves one EX source operand against the EX/MEM and MEM/WB
// producers. EX/MEM is younger and therefore wins; register 0 is never forwarded.
// Ports:
//   src_idx, reg_data            - latched source index and register-file value
//   exmem_reg_write/rd/result    - EX/MEM producer
//   memwb_reg_write/rd/data      - MEM/WB producer
//   fwd_data                     - resolved operand
module ex_forward_unit
  import pipe_pkg::*;
(
  input  logic [RIDX-1:0] src_idx,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exmem_reg_write,
  input  logic [RIDX-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RIDX-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] fwd_data
);

  logic exmem_hit, memwb_hit;

  always_comb begin
    exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_idx);
    memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_idx);
    fwd_data  = reg_data;
    if (exmem_hit)      fwd_data = exmem_result;
    else if (memwb_hit) fwd_data = memwb_data;
  end

endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue: operand-issue stage in front of the 32-bit ALU.
//   - ID/EX latch with registered ALU operation decode
//   - RAW resolution: forwarding from EX/MEM and MEM/WB plus load-use stall,
//     or, without forwarding, a stall until the producer has left MEM/WB
// Build option: ID_EX_FORWARDING_EN
//   defined   - forwarding muxes present, only load-use stalls (one bubble)
//   undefined - operands straight from latched register data, stall on any
//               in-flight producer in ID/EX, EX/MEM or MEM/WB
// Ports:
//   clk, reset (sync, active high)
//   id_*            - decoded instruction from ID
//   exmem_*, memwb_* - producers for forwarding / hazard detection
//   flush           - squash the instruction entering ID/EX
//   id_stall        - hold PC and IF/ID
//   alu_a/b/operation, ex_* - EX stage operands and control
module id_ex_issue
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        id_alu_src,
  input  logic [1:0]  id_alu_op,
  input  logic [5:0]  id_funct,
  input  logic        id_reg_dst,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_branch,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  input  logic        flush,
  output logic        id_stall,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_operation,
  output logic        ex_valid,
  output logic [4:0]  ex_dest,
  output logic [31:0] ex_store_data,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch
);

  idex_t ex_q, ex_d;
  logic [XLEN-1:0] rs_val, rt_val;
  logic uses_rt, hazard;

  // ---------------- operand resolution ----------------
`ifdef ID_EX_FORWARDING_EN
  ex_forward_unit u_fwd_rs (
    .src_idx(ex_q.rs), .reg_data(ex_q.rs_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .fwd_data(rs_val)
  );
  ex_forward_unit u_fwd_rt (
    .src_idx(ex_q.rt), .reg_data(ex_q.rt_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .fwd_data(rt_val)
  );
`else
  assign rs_val = ex_q.rs_data;
  assign rt_val = ex_q.rt_data;
  // Forwarding-only inputs and latched indices have no reader in this build.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_result, memwb_data, ex_q.rs, ex_q.rt};
`endif

  // ---------------- hazard detection ----------------
  always_comb begin
    uses_rt = !id_alu_src || id_mem_write;
`ifdef ID_EX_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time.
    hazard = src_hit(ex_q.valid && ex_q.mem_read, ex_q.dest, id_rs, id_rt, uses_rt);
`else
    hazard = src_hit(ex_q.valid && ex_q.reg_write, ex_q.dest, id_rs, id_rt, uses_rt)
           | src_hit(exmem_reg_write, exmem_rd, id_rs, id_rt, uses_rt)
           | src_hit(memwb_reg_write, memwb_rd, id_rs, id_rt, uses_rt);
`endif
    id_stall = hazard && !reset;
  end

  // ---------------- ID/EX latch ----------------
  always_comb begin
    ex_d = '0;   // reset value and bubble share the all-zero encoding
    if (!reset && !flush && !hazard && id_valid) begin
      ex_d.valid     = 1'b1;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.rs_data   = id_rs_data;
      ex_d.rt_data   = id_rt_data;
      ex_d.imm       = id_imm;
      ex_d.alu_src   = id_alu_src;
      ex_d.op        = decode_op(id_alu_op, id_funct);
      ex_d.dest      = id_reg_dst ? id_rd : id_rt;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.mem_write = id_mem_write;
      ex_d.branch    = id_branch;
    end
  end

  always_ff @(posedge clk) begin
    ex_q <= ex_d;
  end

  // ---------------- EX outputs ----------------
  assign alu_a         = rs_val;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : rt_val;
  assign ex_store_data = rt_val;
  assign alu_operation = ex_q.op;
  assign ex_valid      = ex_q.valid;
  assign ex_dest       = ex_q.dest;
  assign ex_reg_write  = ex_q.valid && ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid && ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid && ex_q.mem_write;
  assign ex_branch     = ex_q.valid && ex_q.branch;

endmodule

// File: tb/tb_id_ex_issue.sv
module tb_id_ex_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        flush;
  logic        id_stall;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_operation;
  logic        ex_valid;
  logic [4:0]  ex_dest;
  logic [31:0] ex_store_data;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_issue dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .flush(flush), .id_stall(id_stall),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_store_data(ex_store_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_alu_src = 0; id_alu_op = 2'b00; id_funct = 0;
    id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
    flush = 0;
  endtask

  task automatic clear_pipe();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic idle();
    clear_id();
    clear_pipe();
    tick();
  endtask

  // lw $8, 0($0): dest = rt = 8
  task automatic drive_lw8();
    clear_id();
    id_valid = 1; id_rt = 5'd8; id_alu_src = 1; id_alu_op = 2'b00;
    id_mem_read = 1; id_reg_write = 1; id_reg_dst = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_id(); clear_pipe();
    // a pending dependency that would stall if reset did not mask it
    id_valid = 1; id_rs = 5'd1; exmem_reg_write = 1; exmem_rd = 5'd1;
    tick(); tick();
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", id_stall); end
    checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000",
                         {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}); end
    checks++; if (alu_operation !== 4'b0000) begin errors++; $display("FAIL reset_op: got %b want 0000", alu_operation); end
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL reset_a: got %h want 0", alu_a); end
    checks++; if (alu_b !== 32'h0) begin errors++; $display("FAIL reset_b: got %h want 0", alu_b); end
    checks++; if ({ex_dest, ex_store_data} !== 37'h0) begin
      errors++; $display("FAIL reset_dest_store: got %h/%h want 0/0", ex_dest, ex_store_data); end
    reset = 0;
    clear_id(); clear_pipe();
  endtask

  task automatic test_rtype_and();
    clear_id(); clear_pipe();
    // add $4, $1, $2
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd4;
    id_rs_data = 32'h0F; id_rt_data = 32'h3C;
    id_alu_op = 2'b10; id_funct = 6'b100000; id_reg_dst = 1; id_reg_write = 1;
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", ex_valid); end
    checks++; if (alu_operation !== 4'b0010) begin errors++; $display("FAIL add_op: got %b want 0010", alu_operation); end
    checks++; if (ex_dest !== 5'd4) begin errors++; $display("FAIL add_dest: got %0d want 4", ex_dest); end
    checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_rw: got %b want 1", ex_reg_write); end
    // and $6, $1, $2 -- no dependency on $4
    id_rd = 5'd6; id_funct = 6'b100100;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL and_stall: got %b want 0", id_stall); end
    tick();
    checks++; if (alu_a !== 32'h0F) begin errors++; $display("FAIL and_a: got %h want 0000000f", alu_a); end
    checks++; if (alu_b !== 32'h3C) begin errors++; $display("FAIL and_b: got %h want 0000003c", alu_b); end
    checks++; if (alu_operation !== 4'b0000) begin errors++; $display("FAIL and_op: got %b want 0000", alu_operation); end
    checks++; if (ex_dest !== 5'd6) begin errors++; $display("FAIL and_dest: got %0d want 6", ex_dest); end
    idle();
  endtask

  task automatic test_decode();
    logic [1:0] aop [9];
    logic [5:0] fn  [9];
    logic [3:0] exp [9];
    aop[0] = 2'b00; fn[0] = 6'b000000; exp[0] = 4'b0010;
    aop[1] = 2'b01; fn[1] = 6'b100100; exp[1] = 4'b0110;
    aop[2] = 2'b10; fn[2] = 6'b100000; exp[2] = 4'b0010;
    aop[3] = 2'b10; fn[3] = 6'b100010; exp[3] = 4'b0110;
    aop[4] = 2'b10; fn[4] = 6'b100100; exp[4] = 4'b0000;
    aop[5] = 2'b10; fn[5] = 6'b100101; exp[5] = 4'b0001;
    aop[6] = 2'b10; fn[6] = 6'b101010; exp[6] = 4'b0111;
    aop[7] = 2'b10; fn[7] = 6'b000111; exp[7] = 4'b1111;
    aop[8] = 2'b11; fn[8] = 6'b100000; exp[8] = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      clear_id();
      id_valid = 1; id_alu_op = aop[i]; id_funct = fn[i];
      tick();
      checks++; if (alu_operation !== exp[i]) begin
        errors++; $display("FAIL decode_%0d: got %b want %b", i, alu_operation, exp[i]); end
    end
    idle();
  endtask

  task automatic test_imm_store();
    clear_id(); clear_pipe();
    // sw $2, -16($1)
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_rs_data = 32'h5; id_rt_data = 32'hCAFE;
    id_alu_src = 1; id_imm = 32'hFFFF_FFF0; id_mem_write = 1;
    tick();
    checks++; if (alu_b !== 32'hFFFF_FFF0) begin errors++; $display("FAIL imm_b: got %h want fffffff0", alu_b); end
    checks++; if (ex_store_data !== 32'hCAFE) begin errors++; $display("FAIL store_data: got %h want 0000cafe", ex_store_data); end
    checks++; if ({ex_mem_write, ex_reg_write} !== 2'b10) begin
      errors++; $display("FAIL store_ctrl: got %b want 10", {ex_mem_write, ex_reg_write}); end
    idle();
  endtask

  task automatic test_bubble();
    clear_id(); clear_pipe();
    // id_valid low with control bits set -> bubble
    id_reg_write = 1; id_mem_write = 1; id_branch = 1;
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_mem_write, ex_branch} !== 4'b0) begin
      errors++; $display("FAIL invalid_bubble: got %b want 0000",
                         {ex_valid, ex_reg_write, ex_mem_write, ex_branch}); end
    // flush of a valid instruction
    id_valid = 1; flush = 1;
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_mem_write, ex_branch} !== 4'b0) begin
      errors++; $display("FAIL flush_bubble: got %b want 0000",
                         {ex_valid, ex_reg_write, ex_mem_write, ex_branch}); end
    idle();
  endtask

  task automatic test_reg0();
    clear_id(); clear_pipe();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_data = 32'hBEEF;
    id_valid = 1; id_rs_data = 32'h77; id_rt_data = 32'h88;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reg0_stall: got %b want 0", id_stall); end
    tick();
    checks++; if (alu_a !== 32'h77) begin errors++; $display("FAIL reg0_a: got %h want 00000077", alu_a); end
    checks++; if (alu_b !== 32'h88) begin errors++; $display("FAIL reg0_b: got %h want 00000088", alu_b); end
    idle();
  endtask

  task automatic test_flush_stall();
    drive_lw8();
    tick();
    clear_id();
    id_valid = 1; id_rs = 5'd8; id_rt = 5'd9; id_rd = 5'd10; id_reg_dst = 1; id_reg_write = 1;
    id_alu_op = 2'b10; id_funct = 6'b100000; flush = 1;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b want 1", id_stall); end
    tick();
    checks++; if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b0) begin
      errors++; $display("FAIL flush_stall_bubble: got %b want 000", {ex_valid, ex_mem_read, ex_reg_write}); end
    idle();
  endtask

`ifdef ID_EX_FORWARDING_EN
  task automatic test_fwd_exmem();
    clear_id(); clear_pipe();
    id_valid = 1; id_rs = 5'd5; id_rs_data = 32'h1;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h1234;
    #1;
    checks++; if (alu_a !== 32'h1234) begin errors++; $display("FAIL fwd_exmem: got %h want 00001234", alu_a); end
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_data = 32'h9999;
    #1;
    checks++; if (alu_a !== 32'h1234) begin errors++; $display("FAIL fwd_double: got %h want 00001234", alu_a); end
    exmem_reg_write = 0;
    #1;
    checks++; if (alu_a !== 32'h9999) begin errors++; $display("FAIL fwd_memwb: got %h want 00009999", alu_a); end
    idle();
  endtask

  task automatic test_load_use();
    int nstall;
    nstall = 0;
    drive_lw8();
    tick();
    clear_id();
    id_valid = 1; id_rs = 5'd8; id_rt = 5'd9; id_rt_data = 32'h11;
    id_alu_op = 2'b10; id_funct = 6'b100000; id_reg_dst = 1; id_rd = 5'd10; id_reg_write = 1;
    #1;
    if (id_stall === 1'b1) nstall++;
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b want 0", ex_valid); end
    // lw now in EX/MEM; its result is the address, not the load data
    exmem_reg_write = 1; exmem_rd = 5'd8; exmem_result = 32'h0BAD;
    #1;
    if (id_stall === 1'b1) nstall++;
    tick();
    checks++; if (nstall !== 1) begin errors++; $display("FAIL lu_stall_count: got %0d want 1", nstall); end
    exmem_reg_write = 0; memwb_reg_write = 1; memwb_rd = 5'd8; memwb_data = 32'hABCD;
    #1;
    checks++; if (alu_a !== 32'hABCD) begin errors++; $display("FAIL lu_fwd_a: got %h want 0000abcd", alu_a); end
    checks++; if ({ex_valid, alu_b} !== {1'b1, 32'h11}) begin
      errors++; $display("FAIL lu_b: got %b/%h want 1/00000011", ex_valid, alu_b); end
    idle();
  endtask
`else
  task automatic test_no_fwd();
    int nstall;
    nstall = 0;
    clear_id(); clear_pipe();
    // addi $3, $0, 7
    id_valid = 1; id_rt = 5'd3; id_alu_src = 1; id_imm = 32'd7; id_reg_write = 1;
    tick();
    // sub $4, $3, $5
    clear_id();
    id_valid = 1; id_rs = 5'd3; id_rt = 5'd5; id_rd = 5'd4; id_reg_dst = 1; id_reg_write = 1;
    id_rs_data = 32'h50; id_rt_data = 32'h10; id_alu_op = 2'b10; id_funct = 6'b100010;
    #1;
    if (id_stall === 1'b1) nstall++;
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL nf_bubble1: got %b want 0", ex_valid); end
    exmem_reg_write = 1; exmem_rd = 5'd3;
    #1;
    if (id_stall === 1'b1) nstall++;
    tick();
    exmem_reg_write = 0; memwb_reg_write = 1; memwb_rd = 5'd3;
    #1;
    if (id_stall === 1'b1) nstall++;
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL nf_bubble3: got %b want 0", ex_valid); end
    memwb_reg_write = 0;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL nf_release: got %b want 0", id_stall); end
    tick();
    checks++; if (nstall !== 3) begin errors++; $display("FAIL nf_stall_count: got %0d want 3", nstall); end
    checks++; if (alu_operation !== 4'b0110) begin errors++; $display("FAIL nf_op: got %b want 0110", alu_operation); end
    checks++; if (alu_a !== 32'h50) begin errors++; $display("FAIL nf_a: got %h want 00000050", alu_a); end
    checks++; if (alu_b !== 32'h10) begin errors++; $display("FAIL nf_b: got %h want 00000010", alu_b); end
    checks++; if ({ex_valid, ex_dest} !== {1'b1, 5'd4}) begin
      errors++; $display("FAIL nf_dest: got %b/%0d want 1/4", ex_valid, ex_dest); end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_rtype_and();
    test_decode();
    test_imm_store();
    test_bubble();
    test_reg0();
    test_flush_stall();
`ifdef ID_EX_FORWARDING_EN
    test_fwd_exmem();
    test_load_use();
`else
    test_no_fwd();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
